// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// if_stage: RV32I instruction-fetch stage with PC, IF/ID register and redirects
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        misalign_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_STEP = 32'd4;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        unused_target_lsb;

  assign pc_plus4  = pc + PC_STEP;
  assign imem_addr = pc;

  // JALR already clears bit 0, so it carries no information here.
  assign unused_target_lsb = redirect_target[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= {RESET_PC[31:2], 2'b00};
      ifid_instr     <= NOP_INSTR;
      ifid_pc        <= 32'h0000_0000;
      ifid_pc_plus4  <= 32'h0000_0000;
      ifid_valid     <= 1'b0;
      misalign_fault <= 1'b0;
      fetch_count    <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // Redirect beats stall: the stalled instruction is on a dead path.
      pc             <= {redirect_target[31:2], 2'b00};
      ifid_instr     <= NOP_INSTR;
      ifid_valid     <= 1'b0;
      misalign_fault <= redirect_target[1];
    end else begin
      misalign_fault <= 1'b0;
      if (!stall) begin
        pc <= pc_plus4;
        if (flush) begin
          ifid_instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end else begin
          ifid_instr    <= imem_instr;
          ifid_pc       <= pc;
          ifid_pc_plus4 <= pc_plus4;
          ifid_valid    <= 1'b1;
          fetch_count   <= fetch_count + 32'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
